// File: rtl/if_stage_pkg.sv
//------------------------------------------------------------------------------
// if_stage_pkg
//   Shared widths, NOP encoding and state encoding for the fetch stage.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package if_stage_pkg;

  localparam int WORD_ADDR_BUS       = 30;
  localparam int DATA_WIDTH_INSN     = 32;
  localparam int DATA_WIDTH_IF_STATE = 2;

  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

  typedef enum logic [DATA_WIDTH_IF_STATE-1:0] {
    IF_STATE_FETCH = 2'd0,
    IF_STATE_HOLD  = 2'd1,
    IF_STATE_DRAIN = 2'd2
  } if_state_e;

endpackage

`default_nettype wire

// File: rtl/if_stage_if.sv
//------------------------------------------------------------------------------
// if_stage_if
//   Instruction-memory request/ack bus. Optional imem_err under IF_BUS_ERR_EN.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface if_stage_if #(
  parameter int ADDR_W = 30,
  parameter int INSN_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INSN_W-1:0] imem_rdata;
`ifdef IF_BUS_ERR_EN
  logic              imem_err;
`endif

  modport master (
    output imem_req,
    output imem_addr,
`ifdef IF_BUS_ERR_EN
    input  imem_err,
`endif
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
`ifdef IF_BUS_ERR_EN
    output imem_err,
`endif
    output imem_ack,
    output imem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/if_hold_buf.sv
//------------------------------------------------------------------------------
// if_hold_buf
//   Single-entry {pc, insn[, err]} buffer for a response captured under stall.
//   Optional err field under IF_BUS_ERR_EN.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_hold_buf
  import if_stage_pkg::*;
#(
  parameter int ADDR_W = WORD_ADDR_BUS,
  parameter int INSN_W = DATA_WIDTH_INSN
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              load,
  input  wire logic              clear,
  input  wire logic [ADDR_W-1:0] pc_in,
  input  wire logic [INSN_W-1:0] insn_in,
`ifdef IF_BUS_ERR_EN
  input  wire logic              err_in,
  output logic                   err,
`endif
  output logic                   valid,
  output logic [ADDR_W-1:0]      pc,
  output logic [INSN_W-1:0]      insn
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSN_W-1:0] insn_q, insn_d;
`ifdef IF_BUS_ERR_EN
  logic              err_q, err_d;
`endif

  // Clear wins so a redirect can never leave a stale entry behind.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    insn_d  = insn_q;
`ifdef IF_BUS_ERR_EN
    err_d   = err_q;
`endif
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      insn_d  = insn_in;
`ifdef IF_BUS_ERR_EN
      err_d   = err_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      insn_q  <= INSN_W'(INSN_NOP);
`ifdef IF_BUS_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
`ifdef IF_BUS_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign insn  = insn_q;
`ifdef IF_BUS_ERR_EN
  assign err   = err_q;
`endif

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
//------------------------------------------------------------------------------
// if_stage
//   RV32I instruction-fetch stage: one outstanding imem request, stall hold
//   buffer, branch/flush redirect with drain. Optional IF_BUS_ERR_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W   = WORD_ADDR_BUS,
  parameter int                INSN_W   = DATA_WIDTH_INSN,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              stall,
  input  wire logic              flush,
  input  wire logic [ADDR_W-1:0] flush_addr,
  input  wire logic              br_taken,
  input  wire logic [ADDR_W-1:0] br_addr,
  if_stage_if.master             imem,
`ifdef IF_BUS_ERR_EN
  output logic                   if_bus_err,
`endif
  output logic [ADDR_W-1:0]      if_pc,
  output logic [INSN_W-1:0]      if_insn,
  output logic                   if_en
);

  localparam logic [INSN_W-1:0] NOP = INSN_W'(INSN_NOP);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [INSN_W-1:0] if_insn_q, if_insn_d;
  logic              if_en_q, if_en_d;
`ifdef IF_BUS_ERR_EN
  logic              if_err_q, if_err_d;
  logic              hold_err;
`endif

  logic              req, done, kill, resp_err;
  logic [ADDR_W-1:0] kill_addr;
  logic [INSN_W-1:0] resp_insn;
  logic              hold_load, hold_clr, hold_valid;
  logic [ADDR_W-1:0] hold_pc;
  logic [INSN_W-1:0] hold_insn;

  assign req       = (state_q == IF_STATE_FETCH || state_q == IF_STATE_DRAIN) && !reset;
  assign done      = req && imem.imem_ack;
  assign kill      = flush || (br_taken && !stall);
  assign kill_addr = flush ? flush_addr : br_addr;
`ifdef IF_BUS_ERR_EN
  assign resp_err  = imem.imem_err;
`else
  assign resp_err  = 1'b0;
`endif
  // A faulted fetch becomes a NOP so nothing architectural executes from it.
  assign resp_insn = resp_err ? NOP : imem.imem_rdata;

  assign imem.imem_req  = req;
  assign imem.imem_addr = (state_q == IF_STATE_DRAIN) ? drain_addr_q : pc_q;

  if_hold_buf #(
    .ADDR_W (ADDR_W),
    .INSN_W (INSN_W)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .load    (hold_load),
    .clear   (hold_clr),
    .pc_in   (pc_q),
    .insn_in (resp_insn),
`ifdef IF_BUS_ERR_EN
    .err_in  (resp_err),
    .err     (hold_err),
`endif
    .valid   (hold_valid),
    .pc      (hold_pc),
    .insn    (hold_insn)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    if_pc_d      = if_pc_q;
    if_insn_d    = if_insn_q;
    if_en_d      = if_en_q;
`ifdef IF_BUS_ERR_EN
    if_err_d     = if_err_q;
`endif
    hold_load    = 1'b0;
    hold_clr     = 1'b0;

    if (kill) begin
      pc_d     = kill_addr;
      if_en_d  = 1'b0;
      hold_clr = 1'b1;
      if (flush) begin
        if_insn_d = NOP;
`ifdef IF_BUS_ERR_EN
        if_err_d  = 1'b0;
`endif
      end
      // An unanswered request must still be retired; remember its address.
      state_d = (req && !imem.imem_ack) ? IF_STATE_DRAIN : IF_STATE_FETCH;
      if (state_q == IF_STATE_FETCH) begin
        drain_addr_d = pc_q;
      end
    end else begin
      unique case (state_q)
        IF_STATE_FETCH: begin
          if (done) begin
            pc_d = pc_q + ADDR_W'(1);
            if (stall) begin
              hold_load = 1'b1;
              state_d   = IF_STATE_HOLD;
            end else begin
              if_pc_d   = pc_q;
              if_insn_d = resp_insn;
              if_en_d   = 1'b1;
`ifdef IF_BUS_ERR_EN
              if_err_d  = resp_err;
`endif
            end
          end else if (!stall) begin
            if_en_d = 1'b0;
          end
        end
        IF_STATE_HOLD: begin
          if (!stall) begin
            if_pc_d   = hold_pc;
            if_insn_d = hold_insn;
            if_en_d   = hold_valid;
`ifdef IF_BUS_ERR_EN
            if_err_d  = hold_err;
`endif
            hold_clr  = 1'b1;
            state_d   = IF_STATE_FETCH;
          end
        end
        IF_STATE_DRAIN: begin
          if (done) begin
            state_d = IF_STATE_FETCH;
          end
        end
        default: state_d = IF_STATE_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IF_STATE_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      if_pc_q      <= '0;
      if_insn_q    <= NOP;
      if_en_q      <= 1'b0;
`ifdef IF_BUS_ERR_EN
      if_err_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      if_pc_q      <= if_pc_d;
      if_insn_q    <= if_insn_d;
      if_en_q      <= if_en_d;
`ifdef IF_BUS_ERR_EN
      if_err_q     <= if_err_d;
`endif
    end
  end

  assign if_pc   = if_pc_q;
  assign if_insn = if_insn_q;
  assign if_en   = if_en_q;
`ifdef IF_BUS_ERR_EN
  assign if_bus_err = if_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//------------------------------------------------------------------------------
// tb_if_stage
//   Directed vector table, wrap/error sequence and randomized in-order check.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_stage;
  import if_stage_pkg::*;

  localparam int ADDR_W = 30;
  localparam int INSN_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic              br_taken;
  logic [ADDR_W-1:0] br_addr;
  logic [ADDR_W-1:0] if_pc;
  logic [INSN_W-1:0] if_insn;
  logic              if_en;
`ifdef IF_BUS_ERR_EN
  logic              if_bus_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_stage_if #(.ADDR_W(ADDR_W), .INSN_W(INSN_W)) imem ();

  if_stage #(
    .ADDR_W   (ADDR_W),
    .INSN_W   (INSN_W),
    .RESET_PC (30'd0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .flush_addr (flush_addr),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .imem       (imem),
`ifdef IF_BUS_ERR_EN
    .if_bus_err (if_bus_err),
`endif
    .if_pc      (if_pc),
    .if_insn    (if_insn),
    .if_en      (if_en)
  );

  // Program image: every word address holds a distinct, recognisable word.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a, 2'b11} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] faddr;
    logic              br;
    logic [ADDR_W-1:0] baddr;
    logic              ack;
    logic [31:0]       rdata;
    logic              e_req;
    logic [ADDR_W-1:0] e_addr;
    logic              e_en;
    logic [ADDR_W-1:0] e_pc;
    logic [31:0]       e_insn;
    logic              chk_nop;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic f, input int fa, input logic b,
                              input int ba, input logic a, input logic [31:0] rd,
                              input logic er, input int ea, input logic en, input int ep,
                              input logic [31:0] ei, input logic cn);
    vec_t v;
    v.stall = s; v.flush = f; v.faddr = ADDR_W'(fa); v.br = b; v.baddr = ADDR_W'(ba);
    v.ack = a; v.rdata = rd; v.e_req = er; v.e_addr = ADDR_W'(ea); v.e_en = en;
    v.e_pc = ADDR_W'(ep); v.e_insn = ei; v.chk_nop = cn;
    return v;
  endfunction

  vec_t vt[20];

  task automatic drive_idle();
    stall = 1'b0; flush = 1'b0; flush_addr = '0; br_taken = 1'b0; br_addr = '0;
    imem.imem_ack = 1'b0; imem.imem_rdata = 32'hCAFE_F00D;
`ifdef IF_BUS_ERR_EN
    imem.imem_err = 1'b0;
`endif
  endtask

  initial begin
    logic [31:0]       NOP32;
    logic [31:0]       A093;
    logic [ADDR_W-1:0] exp_next;
    logic [ADDR_W-1:0] all_ones;
    logic              prev_stall, prev_flush, prev_req, prev_ack, prev_en;
    logic [ADDR_W-1:0] prev_addr, prev_pc;
    logic [31:0]       prev_insn;
    logic [31:0]       r;
    int                n_acc;

    NOP32 = INSN_NOP;
    A093  = 32'h00F6_A093;
    all_ones = '1;

    //     stall flush fa   br ba  ack rdata            req addr en pc  insn             nop
    vt[0]  = mk(0, 0, 0,    0, 0,  1, mem_word(0),     1, 0,    0, 0,  NOP32,           1);
    vt[1]  = mk(0, 0, 0,    0, 0,  1, mem_word(1),     1, 1,    1, 0,  mem_word(0),     0);
    vt[2]  = mk(0, 0, 0,    0, 0,  1, mem_word(2),     1, 2,    1, 1,  mem_word(1),     0);
    vt[3]  = mk(0, 0, 0,    0, 0,  0, 32'h1111_1111,   1, 3,    1, 2,  mem_word(2),     0);
    vt[4]  = mk(0, 0, 0,    0, 0,  0, 32'h2222_2222,   1, 3,    0, 0,  0,               0);
    vt[5]  = mk(0, 0, 0,    0, 0,  1, A093,            1, 3,    0, 0,  0,               0);
    vt[6]  = mk(1, 0, 0,    0, 0,  1, mem_word(4),     1, 4,    1, 3,  A093,            0);
    vt[7]  = mk(1, 0, 0,    0, 0,  0, 32'h3333_3333,   0, 0,    1, 3,  A093,            0);
    vt[8]  = mk(1, 0, 0,    0, 0,  0, 32'h4444_4444,   0, 0,    1, 3,  A093,            0);
    vt[9]  = mk(0, 0, 0,    0, 0,  0, 32'h5555_5555,   0, 0,    1, 3,  A093,            0);
    vt[10] = mk(0, 0, 0,    0, 0,  1, mem_word(5),     1, 5,    1, 4,  mem_word(4),     0);
    vt[11] = mk(0, 0, 0,    1, 10, 0, 32'h6666_6666,   1, 6,    1, 5,  mem_word(5),     0);
    vt[12] = mk(0, 0, 0,    0, 0,  0, 32'h7777_7777,   1, 6,    0, 0,  0,               0);
    vt[13] = mk(0, 0, 0,    0, 0,  1, 32'hDEAD_BEEF,   1, 6,    0, 0,  0,               0);
    vt[14] = mk(0, 0, 0,    0, 0,  1, mem_word(10),    1, 10,   0, 0,  0,               0);
    vt[15] = mk(1, 0, 0,    0, 0,  1, mem_word(11),    1, 11,   1, 10, mem_word(10),    0);
    vt[16] = mk(1, 1, 'h40, 0, 0,  0, 32'h8888_8888,   0, 0,    1, 10, mem_word(10),    0);
    vt[17] = mk(1, 0, 0,    0, 0,  0, 32'h9999_9999,   1, 'h40, 0, 0,  NOP32,           1);
    vt[18] = mk(0, 0, 0,    0, 0,  1, mem_word('h40),  1, 'h40, 0, 0,  NOP32,           1);
    vt[19] = mk(0, 0, 0,    0, 0,  0, 32'hAAAA_AAAA,   1, 'h41, 1, 'h40, mem_word('h40), 0);

    // Reset
    drive_idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_req",     32'(imem.imem_req), 32'd0);
    check("reset_if_en",   32'(if_en),         32'd0);
    check("reset_if_pc",   32'(if_pc),         32'd0);
    check("reset_if_insn", if_insn,            NOP32);
`ifdef IF_BUS_ERR_EN
    check("reset_bus_err", 32'(if_bus_err),    32'd0);
`endif

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      if (i != 0) @(negedge clk);
      reset = 1'b0;
      stall = vt[i].stall; flush = vt[i].flush; flush_addr = vt[i].faddr;
      br_taken = vt[i].br; br_addr = vt[i].baddr;
      imem.imem_ack = vt[i].ack; imem.imem_rdata = vt[i].rdata;
      #1;
      check($sformatf("vec%0d_req", i), 32'(imem.imem_req), 32'(vt[i].e_req));
      if (vt[i].e_req) check($sformatf("vec%0d_addr", i), 32'(imem.imem_addr), 32'(vt[i].e_addr));
      check($sformatf("vec%0d_if_en", i), 32'(if_en), 32'(vt[i].e_en));
      if (vt[i].e_en) begin
        check($sformatf("vec%0d_if_pc", i), 32'(if_pc), 32'(vt[i].e_pc));
        check($sformatf("vec%0d_if_insn", i), if_insn, vt[i].e_insn);
      end
      if (vt[i].chk_nop) check($sformatf("vec%0d_nop", i), if_insn, NOP32);
    end

    // PC wrap at the top of the address space
    @(negedge clk);
    drive_idle();
    flush = 1'b1; flush_addr = all_ones; imem.imem_ack = 1'b1;
    @(negedge clk);
    drive_idle();
    imem.imem_ack = 1'b1; imem.imem_rdata = mem_word(all_ones);
    #1;
    check("wrap_addr_top", 32'(imem.imem_addr), 32'(all_ones));
    check("wrap_flush_nop", if_insn, NOP32);
    @(negedge clk);
    drive_idle();
    #1;
    check("wrap_addr_zero", 32'(imem.imem_addr), 32'd0);
    check("wrap_if_pc",     32'(if_pc), 32'(all_ones));
    check("wrap_if_insn",   if_insn, mem_word(all_ones));
    check("wrap_if_en",     32'(if_en), 32'd1);
`ifdef IF_BUS_ERR_EN
    @(negedge clk);
    drive_idle();
    imem.imem_ack = 1'b1; imem.imem_err = 1'b1; imem.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    drive_idle();
    #1;
    check("err_bus_err", 32'(if_bus_err), 32'd1);
    check("err_if_insn", if_insn, NOP32);
    check("err_if_en",   32'(if_en), 32'd1);
    check("err_if_pc",   32'(if_pc), 32'd0);
`endif

    // Randomized run: accepted instructions must form the program-order stream
    @(negedge clk);
    drive_idle();
    r = $urandom;
    flush = 1'b1; flush_addr = r[ADDR_W-1:0];
    exp_next = flush_addr;
    prev_stall = 1'b0; prev_flush = 1'b1; prev_req = 1'b0; prev_ack = 1'b0;
    prev_en = 1'b0; prev_pc = '0; prev_insn = '0; prev_addr = '0;
    n_acc = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (prev_stall && !prev_flush) begin
        check("rand_stall_en",   32'(if_en),   32'(prev_en));
        check("rand_stall_pc",   32'(if_pc),   32'(prev_pc));
        check("rand_stall_insn", if_insn,      prev_insn);
      end
      if (prev_req && !prev_ack) begin
        check("rand_req_kept",  32'(imem.imem_req),  32'd1);
        check("rand_addr_kept", 32'(imem.imem_addr), 32'(prev_addr));
      end
      stall    = (($urandom % 4) == 0);
      flush    = (($urandom % 40) == 0);
      r        = $urandom;
      flush_addr = r[ADDR_W-1:0];
      br_taken = 1'b0;
      if (if_en && !stall && !flush) begin
        n_acc++;
        check("rand_seq_pc",   32'(if_pc), 32'(exp_next));
        check("rand_seq_insn", if_insn,    mem_word(if_pc));
        exp_next = if_pc + 30'd1;
        if (($urandom % 6) == 0) begin
          r = $urandom;
          br_taken = 1'b1; br_addr = r[ADDR_W-1:0];
          exp_next = br_addr;
        end
      end
      if (flush) exp_next = flush_addr;
      imem.imem_ack   = imem.imem_req && (($urandom % 2) == 1);
      imem.imem_rdata = imem.imem_ack ? mem_word(imem.imem_addr) : $urandom;
      prev_stall = stall; prev_flush = flush;
      prev_req = imem.imem_req; prev_ack = imem.imem_ack; prev_addr = imem.imem_addr;
      prev_en = if_en; prev_pc = if_pc; prev_insn = if_insn;
    end
    check("rand_progress", 32'(n_acc > 300), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
